// File: rtl/delay_ctrl.sv
// Delay-line sequencer: sample-rate divider, ring-buffer pointers and safe offset changes.
// Optional FILL-time statistics counter enabled by defining DELAY_CTRL_STATS_EN.
module delay_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DIV          = 4,
  parameter int unsigned RESET_OFFSET = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [ADDR_WIDTH-1:0] offset_req,
  input  logic                  offset_load,
  output logic                  offset_ack,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  out_valid,
  output logic [1:0]            state
`ifdef DELAY_CTRL_STATS_EN
  ,
  output logic [15:0]           mute_cnt
`endif
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [ADDR_WIDTH-1:0] ResetOffRaw = ADDR_WIDTH'(RESET_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] ResetOff =
      (ResetOffRaw == '0) ? ADDR_WIDTH'(1) : ResetOffRaw;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  // Zero delay would read the slot being written on the same tick.
  function automatic logic [ADDR_WIDTH-1:0] clamp_off(input logic [ADDR_WIDTH-1:0] v);
    return (v == '0) ? ADDR_WIDTH'(1) : v;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_inc;
  logic [ADDR_WIDTH-1:0] offset_cur_q, offset_cur_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_val_q, pend_val_d;
  logic                  out_valid_q, out_valid_d;
  logic                  tick;

  always_comb begin
    tick       = (state_q != StIdle) && (div_q == DivW'(DIV - 1));
    wr_en      = tick;
    rd_en      = tick && (state_q == StRun);
    offset_ack = tick && pend_q;
    wr_addr    = wptr_q;
    rd_addr    = wptr_q - offset_cur_q;
    out_valid  = out_valid_q;
    state      = state_q;
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    wptr_d       = wptr_q;
    fill_cnt_d   = fill_cnt_q;
    fill_cnt_inc = fill_cnt_q + ADDR_WIDTH'(1);
    offset_cur_d = offset_cur_q;
    pend_d       = pend_q;
    pend_val_d   = pend_val_q;
    out_valid_d  = rd_en;

    // A load in the same cycle as an ack re-arms the pending slot for the next tick.
    if (offset_load) begin
      pend_d     = 1'b1;
      pend_val_d = clamp_off(offset_req);
    end else if (offset_ack) begin
      pend_d = 1'b0;
    end
    if (offset_ack) begin
      offset_cur_d = pend_val_q;
    end
    if (tick) begin
      wptr_d = wptr_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      StIdle: begin
        div_d = '0;
        if (run) begin
          state_d    = StFill;
          fill_cnt_d = '0;
        end
      end
      StFill, StRun: begin
        div_d = tick ? '0 : div_q + DivW'(1);
        if (tick) begin
          if (offset_ack && (pend_val_q > offset_cur_q)) begin
            state_d    = StFill;
            fill_cnt_d = '0;
          end else if (state_q == StFill) begin
            fill_cnt_d = fill_cnt_inc;
            if (fill_cnt_inc >= offset_cur_d) begin
              state_d = StRun;
            end
          end
        end
        if (!run) begin
          state_d    = StIdle;
          div_d      = '0;
          fill_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StIdle;
        div_d      = '0;
        fill_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      div_q        <= '0;
      wptr_q       <= '0;
      fill_cnt_q   <= '0;
      offset_cur_q <= ResetOff;
      pend_q       <= 1'b0;
      pend_val_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      wptr_q       <= wptr_d;
      fill_cnt_q   <= fill_cnt_d;
      offset_cur_q <= offset_cur_d;
      pend_q       <= pend_d;
      pend_val_q   <= pend_val_d;
      out_valid_q  <= out_valid_d;
    end
  end

`ifdef DELAY_CTRL_STATS_EN
  logic [15:0] mute_cnt_q, mute_cnt_d;

  always_comb begin
    mute_cnt_d = mute_cnt_q;
    if (tick && (state_q == StFill) && run && (mute_cnt_q != 16'hFFFF)) begin
      mute_cnt_d = mute_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mute_cnt_q <= '0;
    end else begin
      mute_cnt_q <= mute_cnt_d;
    end
  end

  assign mute_cnt = mute_cnt_q;
`endif

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl: vector table of per-tick expectations plus a scoreboard
// queue popped on every RAM write strobe.
module tb_delay_ctrl;
  localparam int AW  = 9;
  localparam int DIV = 4;

  typedef struct {
    logic [AW-1:0] wr;
    logic          rd_en;
    logic [AW-1:0] rd;
    logic          ack;
    logic [1:0]    st;
  } exp_t;

  typedef struct {
    logic          ld;
    logic          coin;
    logic [AW-1:0] req;
    exp_t          e;
  } vec_t;

  logic          clk, rst, run, offset_load;
  logic [AW-1:0] offset_req;
  logic          offset_ack, wr_en, rd_en, out_valid;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0]    state;
`ifdef DELAY_CTRL_STATS_EN
  logic [15:0]   mute_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  logic prev_rd = 0;
  exp_t sb[$];
  vec_t tbl[16];

  delay_ctrl #(.ADDR_WIDTH(AW), .DIV(DIV), .RESET_OFFSET(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .offset_req (offset_req),
    .offset_load(offset_load),
    .offset_ack (offset_ack),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .state      (state)
`ifdef DELAY_CTRL_STATS_EN
    ,
    .mute_cnt   (mute_cnt)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mke(input logic [AW-1:0] wr, input logic rd_en,
                               input logic [AW-1:0] rd, input logic ack, input logic [1:0] st);
    exp_t e;
    e.wr = wr; e.rd_en = rd_en; e.rd = rd; e.ack = ack; e.st = st;
    return e;
  endfunction

  function automatic vec_t mkv(input logic ld, input logic coin, input logic [AW-1:0] req,
                               input exp_t e);
    vec_t v;
    v.ld = ld; v.coin = coin; v.req = req; v.e = e;
    return v;
  endfunction

  // Scoreboard consumer: every write strobe pops one expected tick.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {23'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", {23'd0, wr_addr}, {23'd0, e.wr});
          chk("rd_en", {31'd0, rd_en}, {31'd0, e.rd_en});
          if (e.rd_en) chk("rd_addr", {23'd0, rd_addr}, {23'd0, e.rd});
          chk("offset_ack", {31'd0, offset_ack}, {31'd0, e.ack});
          chk("state", {30'd0, state}, {30'd0, e.st});
        end
      end else if (rd_en || offset_ack) begin
        chk("strobe_without_tick", {30'd0, rd_en, offset_ack}, 32'd0);
      end
      if (out_valid || prev_rd) chk("out_valid", {31'd0, out_valid}, {31'd0, prev_rd});
      prev_rd = rd_en;
    end
  end

  task automatic wait_tick();
    int n = 0;
    while (wr_en !== 1'b1 && n < 4 * DIV) begin
      @(posedge clk); #1;
      n++;
    end
    if (wr_en !== 1'b1) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic step(input vec_t v);
    sb.push_back(v.e);
    if (v.ld && !v.coin) begin
      offset_req = v.req; offset_load = 1;
      @(posedge clk); #1;
      offset_load = 0;
    end
    wait_tick();
    if (v.ld && v.coin) begin
      offset_req = v.req; offset_load = 1;
    end
    @(posedge clk); #1;
    offset_load = 0;
  endtask

  task automatic drain();
    int limit = (sb.size() + 2) * DIV + 8;
    int n = 0;
    while (sb.size() > 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    // Offset 3 loaded in IDLE, then raise to 5 and a coincident clamp-to-1 load.
    tbl[0]  = mkv(1, 0, 9'd3, mke(9'd0, 0, 9'd0, 1, 2'd1));
    tbl[1]  = mkv(0, 0, 9'd0, mke(9'd1, 0, 9'd0, 0, 2'd1));
    tbl[2]  = mkv(0, 0, 9'd0, mke(9'd2, 0, 9'd0, 0, 2'd1));
    tbl[3]  = mkv(0, 0, 9'd0, mke(9'd3, 1, 9'd0, 0, 2'd2));
    tbl[4]  = mkv(0, 0, 9'd0, mke(9'd4, 1, 9'd1, 0, 2'd2));
    tbl[5]  = mkv(1, 0, 9'd5, mke(9'd5, 1, 9'd2, 1, 2'd2));
    for (int i = 6; i <= 10; i++) tbl[i] = mkv(0, 0, 9'd0, mke(AW'(i), 0, 9'd0, 0, 2'd1));
    tbl[11] = mkv(0, 0, 9'd0, mke(9'd11, 1, 9'd6, 0, 2'd2));
    tbl[12] = mkv(1, 1, 9'd0, mke(9'd12, 1, 9'd7, 0, 2'd2));
    tbl[13] = mkv(0, 0, 9'd0, mke(9'd13, 1, 9'd8, 1, 2'd2));
    tbl[14] = mkv(0, 0, 9'd0, mke(9'd14, 1, 9'd13, 0, 2'd2));
    tbl[15] = mkv(1, 0, 9'd256, mke(9'd15, 1, 9'd14, 1, 2'd2));

    rst = 1; run = 0; offset_load = 0; offset_req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_wr_addr", {23'd0, wr_addr}, 32'd0);
    chk("rst_rd_addr", {23'd0, rd_addr}, 32'd256);
    chk("rst_ack", {31'd0, offset_ack}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    mon_en = 1;

    run = 1;
    for (int i = 0; i < 16; i++) step(tbl[i]);

    // Offset 256 fill, then run through the 511->0 pointer wrap.
    for (int k = 16; k <= 271; k++) sb.push_back(mke(AW'(k), 0, 9'd0, 0, 2'd1));
    for (int k = 272; k <= 513; k++) sb.push_back(mke(AW'(k), 1, AW'(k - 256), 0, 2'd2));
    drain();

    // Decrease 256 -> 100 stays in RUN.
    step(mkv(1, 0, 9'd100, mke(9'd2, 1, 9'd258, 1, 2'd2)));
    step(mkv(0, 0, 9'd0, mke(9'd3, 1, 9'd415, 0, 2'd2)));
    step(mkv(0, 0, 9'd0, mke(9'd4, 1, 9'd416, 0, 2'd2)));

    // Increase 100 -> 104, stop mid-FILL, then restart and refill the whole delay.
    step(mkv(1, 0, 9'd104, mke(9'd5, 1, 9'd417, 1, 2'd2)));
    for (int k = 6; k <= 8; k++) step(mkv(0, 0, 9'd0, mke(AW'(k), 0, 9'd0, 0, 2'd1)));
    run = 0;
    repeat (3 * DIV) @(posedge clk);
    #1;
    chk("idle_state", {30'd0, state}, 32'd0);
    chk("idle_wr_addr", {23'd0, wr_addr}, 32'd9);
    chk("idle_rd_addr", {23'd0, rd_addr}, 32'd417);
    run = 1;
    for (int k = 9; k <= 112; k++) sb.push_back(mke(AW'(k), 0, 9'd0, 0, 2'd1));
    sb.push_back(mke(9'd113, 1, 9'd9, 0, 2'd2));
    sb.push_back(mke(9'd114, 1, 9'd10, 0, 2'd2));
    drain();
`ifdef DELAY_CTRL_STATS_EN
    chk("mute_cnt", {16'd0, mute_cnt}, 32'd371);
`endif

    // Reset with a pending load: everything returns to reset values and the load is lost.
    offset_req = 9'd7; offset_load = 1;
    @(posedge clk); #1;
    offset_load = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst2_state", {30'd0, state}, 32'd0);
    chk("rst2_wr_addr", {23'd0, wr_addr}, 32'd0);
    chk("rst2_rd_addr", {23'd0, rd_addr}, 32'd256);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef DELAY_CTRL_STATS_EN
    chk("rst2_mute_cnt", {16'd0, mute_cnt}, 32'd0);
`endif
    step(mkv(0, 0, 9'd0, mke(9'd0, 0, 9'd0, 0, 2'd1)));
    step(mkv(0, 0, 9'd0, mke(9'd1, 0, 9'd0, 0, 2'd1)));

    run = 0;
    repeat (2 * DIV) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
